// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for the subtractive GCD datapath.
// Loads A then B from a valid/ready source, fixes zero operands,
// iterates compare/subtract until eq, and hands off a result or timeout.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   upstream operand handshake (A first, then B)
//   data_in  [DW]         operand bus, sampled here only for zero detection
//   lt, gt, eq            datapath compare flags (A<B, A>B, A==B)
//   sel1, sel2, sel_in    datapath mux selects (1=A, 1=A, 1=subOut)
//   ldA, ldB              datapath register loads
//   done                  datapath result-capture enable
//   out_valid / out_ready downstream result handshake
//   error                 qualifies out_valid: iteration timeout occurred
//   busy                  high in any state other than IDLE
//   iter_count [ITER_W]   subtractions performed for the current operation

module gcd_controller #(
    parameter int DW       = 16,
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     data_in,
    input  logic              lt,
    input  logic              gt,
    input  logic              eq,
    output logic              sel1,
    output logic              sel2,
    output logic              sel_in,
    output logic              ldA,
    output logic              ldB,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              error,
    output logic              busy,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_B,
        S_FIX,
        S_RUN,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    state_e            state_q, state_d;
    logic              a_zero_q, a_zero_d;
    logic              b_zero_q, b_zero_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              din_zero;

    assign din_zero = (data_in == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_zero_q <= 1'b0;
            b_zero_q <= 1'b0;
            iter_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_zero_q <= a_zero_d;
            b_zero_q <= b_zero_d;
            iter_q   <= iter_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_zero_d  = a_zero_q;
        b_zero_d  = b_zero_q;
        iter_d    = iter_q;
        in_ready  = 1'b0;
        sel1      = 1'b0;
        sel2      = 1'b0;
        sel_in    = 1'b0;
        ldA       = 1'b0;
        ldB       = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        error     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ldA      = 1'b1;
                    a_zero_d = din_zero;
                    iter_d   = '0;
                    state_d  = S_WAIT_B;
                end
            end

            S_WAIT_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ldB      = 1'b1;
                    b_zero_d = din_zero;
                    state_d  = S_FIX;
                end
            end

            // A zero operand would stall subtraction forever, so copy
            // the other operand across: gcd(x,0) = x. Both zero falls
            // straight through to RUN, where eq ends it with result 0.
            S_FIX: begin
                sel_in  = 1'b1;
                state_d = S_RUN;
                if (a_zero_q && !b_zero_q) begin
                    sel2 = 1'b1;
                    ldA  = 1'b1;
                end else if (b_zero_q && !a_zero_q) begin
                    sel1 = 1'b1;
                    ldB  = 1'b1;
                end
            end

            // eq wins over the timeout so a result reached exactly on
            // the last allowed subtraction is still reported as good.
            S_RUN: begin
                sel_in = 1'b1;
                if (eq) begin
                    state_d = S_DONE;
                end else if (iter_q == MAX_CNT) begin
                    state_d = S_ERR;
                end else if (gt) begin
                    sel1   = 1'b1;
                    ldA    = 1'b1;
                    iter_d = iter_q + 1'b1;
                end else if (lt) begin
                    sel2   = 1'b1;
                    ldB    = 1'b1;
                    iter_d = iter_q + 1'b1;
                end
            end

            S_DONE: begin
                done      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            S_ERR: begin
                out_valid = 1'b1;
                error     = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: directed bench for gcd_controller with a
// behavioural subtractive datapath alongside it.

module tb_gcd_controller;

    localparam int DW   = 16;
    localparam int IW   = 16;
    localparam int MAXI = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_in;
    logic          lt, gt, eq;
    logic          sel1, sel2, sel_in;
    logic          ldA, ldB;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic          error;
    logic          busy;
    logic [IW-1:0] iter_count;

    always #5 clk = ~clk;

    gcd_controller #(
        .DW       (DW),
        .ITER_W   (IW),
        .MAX_ITER (MAXI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .lt         (lt),
        .gt         (gt),
        .eq         (eq),
        .sel1       (sel1),
        .sel2       (sel2),
        .sel_in     (sel_in),
        .ldA        (ldA),
        .ldB        (ldB),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .error      (error),
        .busy       (busy),
        .iter_count (iter_count)
    );

    // Datapath: subOut = mux1 - mux2, registers load from subOut or data_in.
    logic [DW-1:0] a_r = '0;
    logic [DW-1:0] b_r = '0;
    logic [DW-1:0] res_r = '0;
    logic [DW-1:0] mux1, mux2, sub_out, ld_val;

    assign mux1    = sel1 ? a_r : b_r;
    assign mux2    = sel2 ? a_r : b_r;
    assign sub_out = mux1 - mux2;
    assign ld_val  = sel_in ? sub_out : data_in;
    assign lt      = (a_r < b_r);
    assign gt      = (a_r > b_r);
    assign eq      = (a_r == b_r);

    always_ff @(posedge clk) begin
        if (ldA)  a_r   <= ld_val;
        if (ldB)  b_r   <= ld_val;
        if (done) res_r <= a_r;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          iters;
        bit          err;
        int          lda;
        logic [4:0]  fix;
        logic [4:0]  fmask;
    } vec_t;

    typedef struct {
        int         lat;
        int         iters;
        bit         err;
        int         lda;
        int         dones;
        logic [4:0] fix;
        bit         both;
        bit         run_bad;
        bit         hold_bad;
        bit         after_bad;
        int         iclr;
    } obs_t;

    // Runs one A/B operation; fix = {ldA,ldB,sel1,sel2,sel_in} in FIX.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input int hold, output obs_t o);
        o = '{default: 0};
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = a;
        @(negedge clk);
        data_in = b;
        o.iclr  = int'(iter_count);
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
        o.fix    = {ldA, ldB, sel1, sel2, sel_in};
        o.lat    = 1;
        while (!out_valid && o.lat < 64) begin
            if (ldA) o.lda++;
            if (ldA && ldB) o.both = 1'b1;
            if (in_ready || !busy) o.run_bad = 1'b1;
            @(negedge clk);
            o.lat++;
        end
        o.iters = int'(iter_count);
        o.err   = error;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            data_in  = 16'd77;
            if (!out_valid || in_ready || ldA || ldB ||
                done !== !o.err || error !== o.err)
                o.hold_bad = 1'b1;
            if (done) o.dones++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
        if (done) o.dones++;
        @(negedge clk);
        if (!in_ready || out_valid || done || busy || error)
            o.after_bad = 1'b1;
    endtask

    vec_t vt[11];
    obs_t o;

    initial begin
        vt[0]  = '{16'd24,  16'd18, 16'd6,  3, 1'b0, 1, 5'b00001, 5'b11001};
        vt[1]  = '{16'd7,   16'd7,  16'd7,  0, 1'b0, 0, 5'b00001, 5'b11001};
        vt[2]  = '{16'd0,   16'd9,  16'd9,  0, 1'b0, 1, 5'b10011, 5'b11111};
        vt[3]  = '{16'd12,  16'd0,  16'd12, 0, 1'b0, 0, 5'b01101, 5'b11111};
        vt[4]  = '{16'd0,   16'd0,  16'd0,  0, 1'b0, 0, 5'b00001, 5'b11001};
        vt[5]  = '{16'd100, 16'd1,  16'd0,  4, 1'b1, 4, 5'b00001, 5'b11001};
        vt[6]  = '{16'd15,  16'd10, 16'd5,  2, 1'b0, 1, 5'b00001, 5'b11001};
        vt[7]  = '{16'd9,   16'd12, 16'd3,  3, 1'b0, 2, 5'b00001, 5'b11001};
        vt[8]  = '{16'd21,  16'd6,  16'd3,  4, 1'b0, 3, 5'b00001, 5'b11001};
        vt[9]  = '{16'd5,   16'd1,  16'd1,  4, 1'b0, 4, 5'b00001, 5'b11001};
        vt[10] = '{16'd6,   16'd1,  16'd0,  4, 1'b1, 4, 5'b00001, 5'b11001};

        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outs",
            {in_ready, busy, out_valid, error, done,
             ldA, ldB, sel1, sel2, sel_in}, 10'b1000000000);
        chk("reset_iter", iter_count, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_op(vt[i].a, vt[i].b, 0, o);
            $display("vec %0d: A=%0d B=%0d", i, vt[i].a, vt[i].b);
            chk("latency",   o.lat, vt[i].iters + 3);
            chk("iters",     o.iters, vt[i].iters);
            chk("error",     o.err, vt[i].err);
            chk("lda_count", o.lda, vt[i].lda);
            chk("done_cnt",  o.dones, vt[i].err ? 0 : 1);
            chk("fix_outs",  o.fix & vt[i].fmask, vt[i].fix);
            chk("both_load", o.both, 0);
            chk("run_state", o.run_bad, 0);
            chk("after_hs",  o.after_bad, 0);
            chk("iter_clr",  o.iclr, 0);
            chk("iter_hold", iter_count, vt[i].iters);
            if (!vt[i].err)
                chk("result", res_r, vt[i].res);
        end

        // Downstream stall: DONE must hold steady and refuse new operands.
        do_op(16'd24, 16'd18, 5, o);
        chk("stall_hold",  o.hold_bad, 0);
        chk("stall_dones", o.dones, 6);
        chk("stall_iters", o.iters, 3);
        chk("stall_after", o.after_bad, 0);
        chk("stall_res",   res_r, 6);
        do_op(16'd7, 16'd7, 0, o);
        chk("post_stall_lat", o.lat, 3);
        chk("post_stall_res", res_r, 7);

        // Reset in the middle of RUN.
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 16'd100;
        @(negedge clk);
        data_in = 16'd1;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
        @(negedge clk);
        chk("run_pre_rst", {busy, sel_in, ldA}, 3'b111);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs",
            {in_ready, busy, out_valid, error, done,
             ldA, ldB, sel1, sel2, sel_in}, 10'b1000000000);
        chk("rst_mid_iter", iter_count, 0);
        rst = 1'b0;
        do_op(16'd15, 16'd10, 0, o);
        chk("post_rst_res",   res_r, 5);
        chk("post_rst_iters", o.iters, 2);
        chk("post_rst_err",   o.err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Control FSM that sits directly beside the GCD subtractive datapath (`datapath` module).
- Sequences operand loading from an upstream valid/ready source and drives the datapath's mux selects and register loads.
- Consumes the datapath's lt/gt/eq compare flags and iterates subtraction until eq.
- Presents a completion/error handshake downstream; handles zero operands and bounds iteration with a timeout.

Parameters:
- DW, 16, operand width; matches data_in of the datapath.
- ITER_W, 16, width of the iteration counter.
- MAX_ITER, 65535, subtraction cycles allowed before declaring error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operand valid.
- in_ready  output  1  controller accepts an operand this cycle.
- data_in  input  DW  operand bus (same bus wired to datapath data_in); sampled here only for zero detection.
- lt, gt, eq  input  1 each  datapath compare flags (A<B, A>B, A==B).
- sel1, sel2, sel_in  output  1 each  datapath mux selects (1=A / 1=A / 1=subOut).
- ldA, ldB  output  1 each  datapath register loads.
- done  output  1  datapath result-capture enable.
- out_valid  output  1  result or error available.
- out_ready  input  1  downstream accepts result.
- error  output  1  qualifies out_valid: timeout occurred.
- busy  output  1  high in any state except IDLE.
- iter_count  output  ITER_W  subtractions performed for current operation.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, a_zero=b_zero=0, iter_count=0. All outputs 0 except in_ready=1. Reset mid-operation aborts immediately to IDLE; datapath registers are not cleared.
- State IDLE: in_ready=1, sel_in=0. If in_valid: ldA=1 (same cycle, Mealy), a_zero<=(data_in==0), iter_count<=0, go WAIT_B.
- State WAIT_B: in_ready=1, sel_in=0. If in_valid: ldB=1, b_zero<=(data_in==0), go FIX.
- State FIX: in_ready=0, sel_in=1. One cycle, not counted in iter_count.
  - a_zero & !b_zero: sel1=0, sel2=1, ldA=1, so A<=B-0=B.
  - b_zero & !a_zero: sel1=1, sel2=0, ldB=1, so B<=A.
  - Otherwise: no load.
  - Always go RUN next.
- State RUN: sel_in=1. Load/select outputs are combinational on the compare flags, which reflect the registers updated at the previous edge.
  - eq: no load, go DONE.
  - gt: sel1=1, sel2=0, ldA=1 (A<=A-B); iter_count+1.
  - lt: sel1=0, sel2=1, ldB=1 (B<=B-A); iter_count+1.
  - If iter_count==MAX_ITER and !eq: no load, go ERR.
  - eq has priority over timeout.
  - Exactly one of lt/gt/eq is assumed high; if none is high, no load occurs.
- State DONE: done=1, out_valid=1, error=0. Hold until out_ready, then go IDLE. Result stays valid in the datapath after done drops.
- State ERR: out_valid=1, error=1, done=0. Hold until out_ready, then go IDLE.
- ldA and ldB are never both 1 in the same cycle. In IDLE, WAIT_B and DONE/ERR, sel1=sel2=0.
- in_valid outside IDLE/WAIT_B is ignored; in_ready=0 there.
- iter_count holds its final value through DONE/ERR and clears on the next IDLE accept.
- Latency from B accept to out_valid = 1 (FIX) + iter_count + 1 (eq cycle) + 1 cycles.

Test Plan:
- A=24, B=18, out_ready=1 -> 3 subtractions (A=6, B=12, B=6), done high 1 cycle, result=6, iter_count=3, error=0.
- A=7, B=7 -> iter_count=0, out_valid 3 cycles after B accept, result=7.
- A=0, B=9 -> FIX asserts ldA with sel1=0, sel2=1; result=9, iter_count=0. Repeat with A=12, B=0 -> ldB in FIX, result=12. Repeat with A=0, B=0 -> result=0.
- MAX_ITER=4, A=100, B=1 -> exactly 4 ldA pulses, then ERR: out_valid=1, error=1, done never high.
- A=24, B=18, out_ready held 0 for 5 cycles -> DONE held with done/out_valid stable, in_ready=0; next operand is accepted only after the out_ready cycle.
- rst pulsed during RUN -> next cycle state=IDLE, in_ready=1, all load/select outputs 0. A following A=15, B=10 computes 5 correctly.
